// File: rtl/dcache_pkg.sv
// dcache_pkg: geometry, address-field helpers and FSM states
// shared by the M-stage data cache controller and its storage array.
package dcache_pkg;

  localparam int LINES = 64;
  localparam int WORDS = 4;
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    REFILL = 2'd2,
    RESP   = 2'd3
  } stateT;

  // Helpers take a word address (byte address bits [31:2]).
  function automatic logic [OFF_W-1:0] wordOf(input logic [29:0] wa);
    return wa[OFF_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] lineOf(input logic [29:0] wa);
    return wa[OFF_W+IDX_W-1:OFF_W];
  endfunction

  function automatic logic [TAG_W-1:0] tagOf(input logic [29:0] wa);
    return wa[29:OFF_W+IDX_W];
  endfunction

endpackage

// File: rtl/dcache_if.sv
// dcache_if: main-memory request/ack bus of the data cache.
// master = cache controller, slave = memory.
interface dcache_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage, combinational read port,
// registered word and tag+valid write ports; CLR clears all valid bits.
module dcache_array
  import dcache_pkg::*;
(
  input  logic             CLK,
  input  logic             CLR,
  input  logic [IDX_W-1:0] rdLine,
  input  logic [OFF_W-1:0] rdWord,
  output logic             rdValid,
  output logic [TAG_W-1:0] rdTag,
  output logic [31:0]      rdData,
  input  logic             wordWe,
  input  logic             tagWe,
  input  logic [IDX_W-1:0] wrLine,
  input  logic [OFF_W-1:0] wrWord,
  input  logic [31:0]      wrData,
  input  logic [TAG_W-1:0] wrTag
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tagMem  [LINES];
  logic [31:0]      dataMem [LINES*WORDS];

  assign rdValid = valid[rdLine];
  assign rdTag   = tagMem[rdLine];
  assign rdData  = dataMem[{rdLine, rdWord}];

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      valid <= '0;
    end else if (tagWe) begin
      valid[wrLine] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (tagWe) begin
      tagMem[wrLine] <= wrTag;
    end
    if (wordWe) begin
      dataMem[{wrLine, wrWord}] <= wrData;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through no-write-allocate D-cache FSM.
// CPU side: M-stage load/store, hit, refill channel; memory via dcache_if.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        hit,
  output logic        refill_valid,
  output logic [31:0] refill_data,
  output logic        busy,
  output logic        overrun,
  dcache_if.master    mem
);

  stateT            state;
  logic [OFF_W-1:0] beat;
  logic [29:0]      pendWa;
  logic [31:0]      pendData;
  logic             ovr;

  logic [29:0]      rdWa;
  logic             rdValid;
  logic [TAG_W-1:0] rdTag;
  logic [31:0]      rdData;
  logic             lineHit;
  logic             access;
  logic             wordWe;
  logic             tagWe;
  logic [OFF_W-1:0] wrWord;
  logic [31:0]      wrData;
  logic             unusedBits;

  assign unusedBits = ^ALUOutM[1:0];

  // Outside IDLE the array port serves the pending access
  // (store-hit update and the RESP word).
  assign rdWa    = (state == IDLE) ? ALUOutM[31:2] : pendWa;
  assign lineHit = rdValid && (rdTag == tagOf(rdWa));
  assign access  = MemtoRegM | MemWriteM;

  assign hit = !access
             || (state == IDLE && MemtoRegM && lineHit);

  assign ReadDataM    = rdData;
  assign refill_data  = rdData;
  assign refill_valid = (state == RESP);
  assign busy         = (state != IDLE);
  assign overrun      = ovr;

  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    unique case (1'b1)
      (state == WRITE): begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = {pendWa, 2'b00};
        mem.mem_wdata = pendData;
      end
      (state == REFILL): begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = {pendWa[29:OFF_W], beat, 2'b00};
      end
      default: ;
    endcase
  end

  always_comb begin
    wordWe = 1'b0;
    tagWe  = 1'b0;
    wrWord = beat;
    wrData = mem.mem_rdata;
    if (state == WRITE && mem.mem_ack) begin
      wordWe = lineHit;
      wrWord = wordOf(pendWa);
      wrData = pendData;
    end else if (state == REFILL && mem.mem_ack) begin
      wordWe = 1'b1;
      tagWe  = (beat == LAST_BEAT);
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state    <= IDLE;
      beat     <= '0;
      pendWa   <= '0;
      pendData <= '0;
      ovr      <= 1'b0;
    end else begin
      if (access && state != IDLE) begin
        ovr <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (MemtoRegM && !lineHit) begin
            pendWa <= ALUOutM[31:2];
            beat   <= '0;
            state  <= REFILL;
          end else if (MemWriteM) begin
            pendWa   <= ALUOutM[31:2];
            pendData <= WriteDataM;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (mem.mem_ack) begin
            state <= IDLE;
          end
        end
        REFILL: begin
          if (mem.mem_ack) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              state <= RESP;
            end
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dcache_array u_array (
    .CLK     (CLK),
    .CLR     (CLR),
    .rdLine  (lineOf(rdWa)),
    .rdWord  (wordOf(rdWa)),
    .rdValid (rdValid),
    .rdTag   (rdTag),
    .rdData  (rdData),
    .wordWe  (wordWe),
    .tagWe   (tagWe),
    .wrLine  (lineOf(pendWa)),
    .wrWord  (wrWord),
    .wrData  (wrData),
    .wrTag   (tagOf(pendWa))
  );

endmodule
